// File: rtl/aes_mix_columns_enc.sv
// -----------------------------------------------------------------------------
// aes_mix_columns_enc
//   AES-128 MixColumns for the encrypt datapath. It sits between ShiftRows and
//   AddRoundKey in rounds 1..9. All four columns are mixed combinationally in
//   parallel, and the result is registered. Latency is one cycle, and the block
//   accepts a new state on every clock.
//
//   Optional feature macro: MIXCOL_INV_EN
//     When defined, the block adds an Inv input. With Inv=1 it computes
//     InvMixColumns, and with Inv=0 it computes the forward transform. Inv is
//     sampled on the same edge as In.
//
// Ports
//   Clk    in   1    clock, rising edge
//   Rst_n  in   1    asynchronous active-low reset (deassert synchronously)
//   In     in   128  state; In[127:120] = byte 0 (row0,col0), column-major
//   Inv    in   1    (MIXCOL_INV_EN only) 1 = InvMixColumns
//   Out    out  128  registered MixColumns(In), same byte ordering as In
// -----------------------------------------------------------------------------
module aes_mix_columns_enc (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [127:0] In,
`ifdef MIXCOL_INV_EN
    input  logic         Inv,
`endif
    output logic [127:0] Out
);

    // GF(2^8) multiply by x, reduced by 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // One column: bytes s0..s3 run MSB to LSB.
    function automatic logic [31:0] mix_col_fwd(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] r0, r1, r2, r3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        r0 = xtime(s0) ^ mul3(s1) ^ s2 ^ s3;
        r1 = s0 ^ xtime(s1) ^ mul3(s2) ^ s3;
        r2 = s0 ^ s1 ^ xtime(s2) ^ mul3(s3);
        r3 = mul3(s0) ^ s1 ^ s2 ^ xtime(s3);
        return {r0, r1, r2, r3};
    endfunction

`ifdef MIXCOL_INV_EN
    // The inverse coefficients 9, b, d and e are built from x2/x4/x8 of each byte.
    // m9 = 8+1, mb = 8+2+1, md = 8+4+1, me = 8+4+2.
    function automatic logic [31:0] mix_col_inv(input logic [31:0] col);
        logic [7:0] s [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            s[i]  = col[31-8*i -: 8];
            x2    = xtime(s[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    // Stage p0: combinational mix of all four columns.
    logic [127:0] mix_p0;

    always_comb begin
        mix_p0 = '0;
        for (int c = 0; c < 4; c++) begin
`ifdef MIXCOL_INV_EN
            mix_p0[127-32*c -: 32] = Inv ? mix_col_inv(In[127-32*c -: 32])
                                         : mix_col_fwd(In[127-32*c -: 32]);
`else
            mix_p0[127-32*c -: 32] = mix_col_fwd(In[127-32*c -: 32]);
`endif
        end
    end

    // Stage p0 -> output register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Out <= '0;
        end else begin
            Out <= mix_p0;
        end
    end

endmodule

// File: tb/tb_aes_mix_columns_enc.sv
module tb_aes_mix_columns_enc;

    logic         Clk;
    logic         Rst_n;
    logic [127:0] In;
`ifdef MIXCOL_INV_EN
    logic         Inv;
`endif
    logic [127:0] Out;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] exp_q [$];

    aes_mix_columns_enc dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .In    (In),
`ifdef MIXCOL_INV_EN
        .Inv   (Inv),
`endif
        .Out   (Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compared, required finish", n_cmp);
        $fatal(1);
    end

    // Reference model: generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
        logic [7:0] m [4];
        logic [7:0] s [4];
        logic [127:0] r;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) s[k] = st[127-32*c-8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                r[127-32*c-8*row -: 8] = gf_mul(m[(4-row)%4], s[0]) ^
                                         gf_mul(m[(5-row)%4], s[1]) ^
                                         gf_mul(m[(6-row)%4], s[2]) ^
                                         gf_mul(m[(7-row)%4], s[3]);
            end
        end
        return r;
    endfunction

    task automatic test_reset();
        logic [127:0] e;
        Rst_n = 1'b0;
        In    = 128'h6353e08c0960e104cd70b751bacad0e7;
        #3;
        e = '0;
        n_cmp++;
        if (Out !== e) begin
            n_err++;
            $display("FAIL reset_value: got %h, required %h", Out, e);
        end
        repeat (2) @(posedge Clk);
        #1;
        n_cmp++;
        if (Out !== e) begin
            n_err++;
            $display("FAIL reset_held: got %h, required %h", Out, e);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_single_vector();
        logic [127:0] e;
        @(negedge Clk);
        In = 128'h6353e08c0960e104cd70b751bacad0e7;
        exp_q.push_back(128'h5f72641557f5bc92f7be3b291db9f91a);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (Out !== e) begin
            n_err++;
            $display("FAIL fips_vector: got %h, required %h", Out, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vin [3];
        logic [127:0] vout [3];
        logic [127:0] e;
        vin[0]  = 128'ha7be1a6997ad739bd8c9ca451f618b61;
        vout[0] = 128'hff87968431d86a51645151fa773ad009;
        vin[1]  = 128'h3bd92268fc74fb735767cbe0c0590e2d;
        vout[1] = 128'h4c9c1e66f771f0762c3f868e534df256;
        vin[2]  = 128'h2d6d7ef03f33e334093602dd5bfb12c7;
        vout[2] = 128'h6385b79ffc538df997be478e7547d691;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            In = vin[i];
            exp_q.push_back(vout[i]);
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (Out !== e) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %h, required %h", i, Out, e);
            end
        end
    endtask

    task automatic test_columns();
        logic [127:0] e;
        @(negedge Clk);
        In = 128'hdb135345_c6c6c6c6_01010101_2d26314c;
        exp_q.push_back(128'h8e4da1bc_c6c6c6c6_01010101_4d7ebdf8);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (Out !== e) begin
            n_err++;
            $display("FAIL column_vectors: got %h, required %h", Out, e);
        end
    endtask

    task automatic test_hold();
        logic [127:0] e;
        @(negedge Clk);
        In = 128'hdb135345_00000000_80808080_f20a225c;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model(In, 1'b0));
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (Out !== e) begin
                n_err++;
                $display("FAIL hold[%0d]: got %h, required %h", i, Out, e);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [127:0] e;
        for (int i = 0; i < 24; i++) begin
            @(negedge Clk);
            In = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(model(In, 1'b0));
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (Out !== e) begin
                n_err++;
                $display("FAIL random[%0d]: in %h got %h, required %h", i, In, Out, e);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [127:0] e;
        @(negedge Clk);
        In = 128'h6353e08c0960e104cd70b751bacad0e7;
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        e = '0;
        n_cmp++;
        if (Out !== e) begin
            n_err++;
            $display("FAIL midstream_reset: got %h, required %h", Out, e);
        end
        exp_q.delete();
        @(negedge Clk);
        Rst_n = 1'b1;
        In = 128'ha7be1a6997ad739bd8c9ca451f618b61;
        exp_q.push_back(128'hff87968431d86a51645151fa773ad009);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (Out !== e) begin
            n_err++;
            $display("FAIL after_release: got %h, required %h", Out, e);
        end
    endtask

`ifdef MIXCOL_INV_EN
    task automatic test_inverse();
        logic [127:0] e;
        @(negedge Clk);
        Inv = 1'b1;
        In  = 128'h5f72641557f5bc92f7be3b291db9f91a;
        exp_q.push_back(128'h6353e08c0960e104cd70b751bacad0e7);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (Out !== e) begin
            n_err++;
            $display("FAIL inv_vector: got %h, required %h", Out, e);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            Inv = i[0];
            In  = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(model(In, Inv));
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (Out !== e) begin
                n_err++;
                $display("FAIL inv_random[%0d]: got %h, required %h", i, Out, e);
            end
        end
        @(negedge Clk);
        Inv = 1'b0;
    endtask
`endif

    initial begin
        Rst_n = 1'b0;
        In    = '0;
`ifdef MIXCOL_INV_EN
        Inv   = 1'b0;
`endif
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_columns();
        test_hold();
        test_random_stream();
        test_reset_midstream();
`ifdef MIXCOL_INV_EN
        test_inverse();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
